pipe_addsub: RTL

- Parametrised, pipelined integer adder/subtractor with carry-in and a valid/ready handshake on both sides.
- Splits the operand into STAGES equal chunks, one chunk per pipeline stage, with the carry rippling through registers.
- Produces carry, signed-overflow, zero and negative flags, and carries a caller tag alongside each result.
- Serves wide datapaths (multi-precision arithmetic, address generation) where a single-cycle add limits Fmax.

---
 rtl/pipe_addsub.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/pipe_addsub.sv
// Pipelined adder/subtractor. The operand is split into STAGES chunks, one chunk per stage,
// and the carry ripples through registers. Every stage has an elastic valid/ready handshake.
module pipe_addsub #(
  parameter int OPERAND_WIDTH = 32,
  parameter int STAGES        = 4,
  parameter int TAG_WIDTH     = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [OPERAND_WIDTH-1:0] in_a,
  input  logic [OPERAND_WIDTH-1:0] in_b,
  input  logic [1:0]               in_op,
  input  logic                     in_cin,
  input  logic [TAG_WIDTH-1:0]     in_tag,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [OPERAND_WIDTH-1:0] out_res,
  output logic                     out_carry,
  output logic                     out_ovf,
  output logic                     out_zero,
  output logic                     out_neg,
  output logic [TAG_WIDTH-1:0]     out_tag
);

  localparam int CW  = OPERAND_WIDTH / STAGES;
  localparam int MSB = OPERAND_WIDTH - 1;

  logic [STAGES-1:0]        valid_q, valid_d;
  logic [STAGES-1:0]        carry_q, carry_d;
  logic [OPERAND_WIDTH-1:0] a_q   [STAGES];
  logic [OPERAND_WIDTH-1:0] a_d   [STAGES];
  logic [OPERAND_WIDTH-1:0] bp_q  [STAGES];
  logic [OPERAND_WIDTH-1:0] bp_d  [STAGES];
  logic [OPERAND_WIDTH-1:0] sum_q [STAGES];
  logic [OPERAND_WIDTH-1:0] sum_d [STAGES];
  logic [TAG_WIDTH-1:0]     tag_q [STAGES];
  logic [TAG_WIDTH-1:0]     tag_d [STAGES];

  // Per-stage inputs: stage 0 sees the port, stage k sees register k-1.
  logic [OPERAND_WIDTH-1:0] a_in   [STAGES];
  logic [OPERAND_WIDTH-1:0] bp_in  [STAGES];
  logic [OPERAND_WIDTH-1:0] sum_in [STAGES];
  logic [TAG_WIDTH-1:0]     tag_in [STAGES];
  logic [STAGES-1:0]        cin_in, vin;
  logic [STAGES-1:0]        load;

  // Stage k may load if any stage at or after k is empty, or the consumer takes the result.
  // Written in closed form so the ready chain depends only on registers and out_ready.
  always_comb begin : ready_chain
    logic hole;
    // NOTE: combinational logic uses blocking assignments; the running 'hole' value is
    // consumed within the same pass, which non-blocking assignments would not allow.
    hole = 1'b0;
    load = '0;
    for (int k = STAGES - 1; k >= 0; k--) begin
      hole    = hole | ~valid_q[k];
      load[k] = out_ready | hole;
    end
  end

  always_comb begin : stage_inputs
    a_in[0]   = in_a;
    bp_in[0]  = in_op[0] ? ~in_b : in_b;
    sum_in[0] = '0;
    cin_in    = '0;
    cin_in[0] = in_op[1] ? in_cin : in_op[0];
    tag_in[0] = in_tag;
    vin       = '0;
    vin[0]    = in_valid;
    for (int k = 1; k < STAGES; k++) begin
      a_in[k]   = a_q[k-1];
      bp_in[k]  = bp_q[k-1];
      sum_in[k] = sum_q[k-1];
      cin_in[k] = carry_q[k-1];
      tag_in[k] = tag_q[k-1];
      vin[k]    = valid_q[k-1];
    end
  end

  always_comb begin : stage_next
    logic [CW:0] chunk;
    chunk   = '0;
    valid_d = valid_q;
    carry_d = carry_q;
    for (int k = 0; k < STAGES; k++) begin
      chunk = {1'b0, a_in[k][k*CW +: CW]} + {1'b0, bp_in[k][k*CW +: CW]}
            + {{CW{1'b0}}, cin_in[k]};
      a_d[k]   = a_q[k];
      bp_d[k]  = bp_q[k];
      sum_d[k] = sum_q[k];
      tag_d[k] = tag_q[k];
      if (load[k]) begin
        valid_d[k]           = vin[k];
        a_d[k]               = a_in[k];
        bp_d[k]              = bp_in[k];
        sum_d[k]             = sum_in[k];
        sum_d[k][k*CW +: CW] = chunk[CW-1:0];
        carry_d[k]           = chunk[CW];
        tag_d[k]             = tag_in[k];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the data registers are reset too, not just the valid bits, because the
      // result and flag outputs must read 0 straight after reset.
      valid_q <= '0;
      carry_q <= '0;
      for (int k = 0; k < STAGES; k++) begin
        a_q[k]   <= '0;
        bp_q[k]  <= '0;
        sum_q[k] <= '0;
        tag_q[k] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      carry_q <= carry_d;
      for (int k = 0; k < STAGES; k++) begin
        a_q[k]   <= a_d[k];
        bp_q[k]  <= bp_d[k];
        sum_q[k] <= sum_d[k];
        tag_q[k] <= tag_d[k];
      end
    end
  end

  assign in_ready  = load[0];
  assign out_valid = valid_q[STAGES-1];
  assign out_res   = sum_q[STAGES-1];
  assign out_carry = carry_q[STAGES-1];
  assign out_ovf   = (a_q[STAGES-1][MSB] == bp_q[STAGES-1][MSB]) &&
                     (sum_q[STAGES-1][MSB] != a_q[STAGES-1][MSB]);
  // Gated by valid so that an all-zero reset state does not report zero=1.
  assign out_zero  = valid_q[STAGES-1] && (sum_q[STAGES-1] == '0);
  assign out_neg   = sum_q[STAGES-1][MSB];
  assign out_tag   = tag_q[STAGES-1];

endmodule
